// File: rtl/vga_timing_gen_pkg.sv
// vga_timing_gen_pkg: shared 640x480@60 timing defaults and axis total helper
package vga_timing_gen_pkg;
  localparam int H_ACTIVE_D = 640;
  localparam int H_FP_D     = 16;
  localparam int H_SYNC_D   = 96;
  localparam int H_BP_D     = 48;
  localparam int V_ACTIVE_D = 480;
  localparam int V_FP_D     = 10;
  localparam int V_SYNC_D   = 2;
  localparam int V_BP_D     = 33;
  localparam int CW_D       = 10;
  function automatic int axis_total(input int a, input int f, input int s, input int b);
    return a + f + s + b;
  endfunction
endpackage

// File: rtl/timing_axis.sv
// timing_axis: one counter axis (active, front porch, sync, back porch) with registered sync decode; ports: clk, reset_n, i_adv, i_restart -> o_cnt, o_sync, o_wrap, o_nxt_act, o_nxt_zero
module timing_axis
  import vga_timing_gen_pkg::*;
#(
  parameter int ACTIVE = H_ACTIVE_D,
  parameter int FP     = H_FP_D,
  parameter int SYNC   = H_SYNC_D,
  parameter int BP     = H_BP_D,
  parameter bit POL    = 1'b0,
  parameter int CW     = CW_D
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          i_adv,
  input  logic          i_restart,
  output logic [CW-1:0] o_cnt,
  output logic          o_sync,
  output logic          o_wrap,
  output logic          o_nxt_act,
  output logic          o_nxt_zero
);
  localparam int TOTAL = axis_total(ACTIVE, FP, SYNC, BP);
  localparam logic [CW-1:0] LAST    = CW'(TOTAL - 1);
  localparam logic [CW-1:0] SYNC_LO = CW'(ACTIVE + FP);
  localparam logic [CW-1:0] SYNC_HI = CW'(ACTIVE + FP + SYNC);
  localparam logic [CW-1:0] ACT_END = CW'(ACTIVE);
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_nxt;
  logic          r_sync;
  assign o_wrap     = i_adv && (r_cnt == LAST);
  assign w_nxt      = i_restart ? '0 : o_wrap ? '0 : i_adv ? r_cnt + CW'(1) : r_cnt;
  assign o_nxt_act  = w_nxt < ACT_END;
  assign o_nxt_zero = w_nxt == '0;
  // sync is decoded from the next count so it lines up with o_cnt
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_cnt  <= '0;
      r_sync <= ~POL;
    end else begin
      r_cnt  <= w_nxt;
      r_sync <= (w_nxt >= SYNC_LO && w_nxt < SYNC_HI) ? POL : ~POL;
    end
  assign o_cnt  = r_cnt;
  assign o_sync = r_sync;
endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA raster timing; ports: clk, reset_n, pix_en, restart -> x, y, hsync, vsync, active, line_start, frame_start, frame_cnt
module vga_timing_gen
  import vga_timing_gen_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_D,
  parameter int H_FP     = H_FP_D,
  parameter int H_SYNC   = H_SYNC_D,
  parameter int H_BP     = H_BP_D,
  parameter int V_ACTIVE = V_ACTIVE_D,
  parameter int V_FP     = V_FP_D,
  parameter int V_SYNC   = V_SYNC_D,
  parameter int V_BP     = V_BP_D,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int CW       = CW_D
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          pix_en,
  input  logic          restart,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic          hsync,
  output logic          vsync,
  output logic          active,
  output logic          line_start,
  output logic          frame_start,
  output logic [7:0]    frame_cnt
);
  logic       w_h_wrap, w_v_wrap, w_h_act, w_v_act, w_h_zero, w_v_zero;
  logic       r_active, r_line_start, r_frame_start;
  logic [7:0] r_frame_cnt;
  timing_axis #(.ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .POL(HS_POL), .CW(CW)) u_h (
    .clk(clk), .reset_n(reset_n), .i_adv(pix_en), .i_restart(restart),
    .o_cnt(x), .o_sync(hsync), .o_wrap(w_h_wrap), .o_nxt_act(w_h_act), .o_nxt_zero(w_h_zero)
  );
  // vertical axis steps only when the horizontal axis wraps
  timing_axis #(.ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .POL(VS_POL), .CW(CW)) u_v (
    .clk(clk), .reset_n(reset_n), .i_adv(w_h_wrap), .i_restart(restart),
    .o_cnt(y), .o_sync(vsync), .o_wrap(w_v_wrap), .o_nxt_act(w_v_act), .o_nxt_zero(w_v_zero)
  );
  // combined flags registered from the axes' next-value decode, reset matches pixel (0,0)
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_active      <= 1'b1;
      r_line_start  <= 1'b1;
      r_frame_start <= 1'b1;
      r_frame_cnt   <= '0;
    end else begin
      r_active      <= w_h_act && w_v_act;
      r_line_start  <= w_h_zero;
      r_frame_start <= w_h_zero && w_v_zero;
      r_frame_cnt   <= r_frame_cnt + 8'(w_v_wrap && !restart);
    end
  assign active      = r_active;
  assign line_start  = r_line_start;
  assign frame_start = r_frame_start;
  assign frame_cnt   = r_frame_cnt;
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: table vectors, randomized model checks and corner sequences for vga_timing_gen
module tb_vga_timing_gen;
  localparam int HA = 4, HF = 1, HS = 2, HB = 1, VA = 3, VF = 1, VS = 1, VB = 1;
  localparam int HT = HA + HF + HS + HB, VT = VA + VF + VS + VB;
  typedef struct {
    bit pe; bit rs; int x; int y; bit hs; bit vs; bit act; bit ls; bit fs; int fc;
  } vec_t;
  logic clk = 1'b0, rst_n = 1'b0, rstd_n = 1'b0, pe = 1'b0, rs = 1'b0;
  logic [9:0] x, y, xd, yd;
  logic hs, vs, act, ls, fs, hsd, vsd, actd, lsd, fsd;
  logic [7:0] fc, fcd;
  int n_tests = 0, n_fail = 0;
  int mx = 0, my = 0, mf = 0;
  vec_t tbl[13];
  always #5 clk = ~clk;
  vga_timing_gen #(.H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
                   .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .CW(10)) dut (
    .clk(clk), .reset_n(rst_n), .pix_en(pe), .restart(rs), .x(x), .y(y), .hsync(hs), .vsync(vs),
    .active(act), .line_start(ls), .frame_start(fs), .frame_cnt(fc)
  );
  vga_timing_gen dut_d (
    .clk(clk), .reset_n(rstd_n), .pix_en(1'b1), .restart(1'b0), .x(xd), .y(yd), .hsync(hsd), .vsync(vsd),
    .active(actd), .line_start(lsd), .frame_start(fsd), .frame_cnt(fcd)
  );
  task automatic chk(input string nm, input int a, input int e);
    n_tests++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, a, e, $time);
    end
  endtask
  task automatic model_step(input bit p, input bit r);
    if (r) begin
      mx = 0;
      my = 0;
    end else if (p) begin
      mx++;
      if (mx == HT) begin
        mx = 0;
        my++;
        if (my == VT) begin
          my = 0;
          mf = (mf + 1) % 256;
        end
      end
    end
  endtask
  task automatic chk_all(input string t);
    chk({t, " x"}, int'(x), mx);
    chk({t, " y"}, int'(y), my);
    chk({t, " hsync"}, int'(hs), (mx >= HA + HF && mx < HA + HF + HS) ? 0 : 1);
    chk({t, " vsync"}, int'(vs), (my >= VA + VF && my < VA + VF + VS) ? 0 : 1);
    chk({t, " active"}, int'(act), (mx < HA && my < VA) ? 1 : 0);
    chk({t, " line_start"}, int'(ls), (mx == 0) ? 1 : 0);
    chk({t, " frame_start"}, int'(fs), (mx == 0 && my == 0) ? 1 : 0);
    chk({t, " frame_cnt"}, int'(fc), mf);
  endtask
  task automatic step(input bit p, input bit r, input string t);
    pe = p;
    rs = r;
    @(posedge clk);
    #1;
    model_step(p, r);
    chk_all(t);
  endtask
  task automatic chk_reset_vals(input string t);
    chk({t, " x"}, int'(x), 0);
    chk({t, " y"}, int'(y), 0);
    chk({t, " hsync"}, int'(hs), 1);
    chk({t, " vsync"}, int'(vs), 1);
    chk({t, " active"}, int'(act), 1);
    chk({t, " line_start"}, int'(ls), 1);
    chk({t, " frame_start"}, int'(fs), 1);
    chk({t, " frame_cnt"}, int'(fc), 0);
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    pe = 1'b0;
    rs = 1'b0;
    @(posedge clk);
    #1;
    chk_reset_vals("in_reset");
    rst_n = 1'b1;
    mx = 0;
    my = 0;
    mf = 0;
  endtask
  initial begin
    bit found;
    int saved_fc;
    tbl[0]  = '{1, 0, 1, 0, 1, 1, 1, 0, 0, 0};
    tbl[1]  = '{1, 0, 2, 0, 1, 1, 1, 0, 0, 0};
    tbl[2]  = '{1, 0, 3, 0, 1, 1, 1, 0, 0, 0};
    tbl[3]  = '{1, 0, 4, 0, 1, 1, 0, 0, 0, 0};
    tbl[4]  = '{1, 0, 5, 0, 0, 1, 0, 0, 0, 0};
    tbl[5]  = '{1, 0, 6, 0, 0, 1, 0, 0, 0, 0};
    tbl[6]  = '{1, 0, 7, 0, 1, 1, 0, 0, 0, 0};
    tbl[7]  = '{1, 0, 0, 1, 1, 1, 1, 1, 0, 0};
    tbl[8]  = '{0, 0, 0, 1, 1, 1, 1, 1, 0, 0};
    tbl[9]  = '{1, 0, 1, 1, 1, 1, 1, 0, 0, 0};
    tbl[10] = '{0, 1, 0, 0, 1, 1, 1, 1, 1, 0};
    tbl[11] = '{1, 1, 0, 0, 1, 1, 1, 1, 1, 0};
    tbl[12] = '{1, 0, 1, 0, 1, 1, 1, 0, 0, 0};
    #12;
    chk_reset_vals("por");
    rst_n = 1'b1;
    for (int i = 0; i < 13; i++) begin
      pe = tbl[i].pe;
      rs = tbl[i].rs;
      @(posedge clk);
      #1;
      model_step(tbl[i].pe, tbl[i].rs);
      chk($sformatf("tbl%0d x", i), int'(x), tbl[i].x);
      chk($sformatf("tbl%0d y", i), int'(y), tbl[i].y);
      chk($sformatf("tbl%0d hsync", i), int'(hs), int'(tbl[i].hs));
      chk($sformatf("tbl%0d vsync", i), int'(vs), int'(tbl[i].vs));
      chk($sformatf("tbl%0d active", i), int'(act), int'(tbl[i].act));
      chk($sformatf("tbl%0d line_start", i), int'(ls), int'(tbl[i].ls));
      chk($sformatf("tbl%0d frame_start", i), int'(fs), int'(tbl[i].fs));
      chk($sformatf("tbl%0d frame_cnt", i), int'(fc), tbl[i].fc);
    end
    do_reset();
    for (int i = 1; i <= 48; i++) step(1'b1, 1'b0, "frame");
    chk("frame48 frame_start", int'(fs), 1);
    chk("frame48 frame_cnt", int'(fc), 1);
    for (int i = 0; i < 16; i++) step(1'(i % 2 == 0), 1'b0, "toggle");
    for (int i = 0; i < 300; i++) step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 19) == 0), "rand");
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      if (mx == 6 && my == 2) found = 1'b1;
      else step(1'b1, 1'b0, "seek62");
    end
    chk("reach x6y2", int'(found), 1);
    saved_fc = mf;
    step(1'b0, 1'b1, "restart");
    chk("restart fs", int'(fs), 1);
    chk("restart fc", int'(fc), saved_fc);
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      if (mx == 3 && my == 4) found = 1'b1;
      else step(1'b1, 1'b0, "seek34");
    end
    chk("reach x3y4", int'(found), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("async");
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    mx = 0;
    my = 0;
    mf = 0;
    step(1'b1, 1'b0, "resume");
    @(posedge clk);
    #1;
    rstd_n = 1'b1;
    for (int c = 1; c <= 801; c++) begin
      @(posedge clk);
      #1;
      chk("def x", int'(xd), c % 800);
      chk("def y", int'(yd), c >= 800 ? 1 : 0);
      chk("def hsync", int'(hsd), (c % 800 >= 656 && c % 800 < 752) ? 0 : 1);
      chk("def active", int'(actd), (c % 800 < 640) ? 1 : 0);
      if (c == 800) begin
        chk("def line_start", int'(lsd), 1);
        chk("def frame_start", int'(fsd), 0);
        chk("def vsync", int'(vsd), 1);
        chk("def frame_cnt", int'(fcd), 0);
      end
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 The block SHALL have parameter H_ACTIVE, default 640, meaning visible pixels per line.
REQ-002 The block SHALL have parameter H_FP, default 16, meaning horizontal front-porch pixels.
REQ-003 The block SHALL have parameter H_SYNC, default 96, meaning horizontal sync-pulse pixels.
REQ-004 The block SHALL have parameter H_BP, default 48, meaning horizontal back-porch pixels.
REQ-005 The block SHALL have parameters V_ACTIVE/V_FP/V_SYNC/V_BP, defaults 480/10/2/33, meaning the vertical equivalents in lines.
REQ-006 The block SHALL have parameters HS_POL and VS_POL, default 0, meaning the asserted level of hsync and vsync.
REQ-007 The block SHALL have parameter CW, default 10, meaning the width of the x and y counters.
REQ-008 The block SHALL have port clk, input, 1 bit: the single clock.
REQ-009 The block SHALL have port reset_n, input, 1 bit: asynchronous active-low reset.
REQ-010 The block SHALL have port pix_en, input, 1 bit: pixel-advance enable.
REQ-011 The block SHALL have port restart, input, 1 bit: synchronous return to pixel (0,0).
REQ-012 The block SHALL have ports x and y, outputs, CW bits each: the current column and line.
REQ-013 The block SHALL have ports hsync and vsync, outputs, 1 bit each: sync pulses at the parameter polarity.
REQ-014 The block SHALL have port active, output, 1 bit: high while x<H_ACTIVE and y<V_ACTIVE.
REQ-015 The block SHALL have ports line_start and frame_start, outputs, 1 bit each: one-pixel strobes.
REQ-016 The block SHALL have port frame_cnt, output, 8 bits: completed-frame count, wrapping.

Function
REQ-017 Totals SHALL be H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP and V_TOTAL likewise; the line order SHALL be active, front porch, sync, back porch.
REQ-018 x SHALL advance by 1 on each clk edge with pix_en=1; at H_TOTAL-1 it SHALL wrap to 0 and y SHALL advance.
REQ-019 y SHALL wrap to 0 when x wraps with y=V_TOTAL-1; frame_cnt SHALL increment (mod 256) on that same edge.
REQ-020 With pix_en=0, all counters and outputs SHALL hold their values.
REQ-021 restart=1 SHALL set x=0, y=0, frame_cnt unchanged on the next edge, regardless of pix_en; restart SHALL take priority over advance.
REQ-022 hsync SHALL equal HS_POL iff H_ACTIVE+H_FP <= x < H_ACTIVE+H_FP+H_SYNC, otherwise ~HS_POL; vsync SHALL follow the same rule on y with the V parameters and VS_POL.
REQ-023 hsync, vsync, active, line_start and frame_start SHALL be registered and computed from the next counter values, so they align with x/y on the same cycle, with zero latency and no combinational decode on the outputs.
REQ-024 line_start SHALL be 1 iff x==0; frame_start SHALL be 1 iff x==0 and y==0. Both SHALL hold for as long as pix_en stalls.
REQ-025 The counters SHALL never reach H_TOTAL or V_TOTAL; the wrap compare SHALL be equality against TOTAL-1.

Reset
REQ-026 reset_n=0 SHALL asynchronously force x=0, y=0 and frame_cnt=0.
REQ-027 During reset, hsync SHALL be ~HS_POL, vsync ~VS_POL, active 1, line_start 1 and frame_start 1, consistent with (0,0).
REQ-028 Reset assertion mid-line or mid-frame SHALL abandon the frame; after deassertion, counting SHALL resume from (0,0) on the first pix_en edge.

Structure
REQ-029 Default timing constants (640x480@60) SHALL live in the shared parameters include so that other video blocks use identical totals.
REQ-030 One sub-module, timing_axis (counter + porch/sync decode, parametrised by ACTIVE/FP/SYNC/BP/POL), SHALL be instantiated twice: once horizontal, and once vertical with its advance gated by the horizontal wrap.

Verification
Small params for V1-V4: H 4/1/2/1 (H_TOTAL=8), V 3/1/1/1 (V_TOTAL=6), POL 0, pix_en=1.
REQ-031 Reset then 8 clocks -> x runs 0..7 then 0; y goes 0->1 on the wrap; hsync is low only at x=5,6; active is high at x=0..3.
REQ-032 48 clocks from reset -> frame_start pulses at cycles 0 and 48; frame_cnt=1; vsync is low only while y=4.
REQ-033 pix_en toggled 1/0 each cycle -> x advances every other cycle; line_start stays high for 2 cycles at x=0.
REQ-034 restart at x=6,y=2 with pix_en=0 -> next cycle x=0, y=0, frame_start=1, frame_cnt unchanged.
REQ-035 reset_n pulsed low asynchronously mid-cycle at x=3,y=4 -> outputs return to the reset values immediately, without waiting for a clk edge.
REQ-036 Default params with 420000 clocks -> x wraps at 799, y wraps at 524; hsync is low at x=656..751; vsync is low at y=490..491; frame_cnt=1.
